// File: rtl/crc8_frame_arb.sv
// Two-requester, frame-granular round-robin sequencer around one CRC-8 (poly 0x07, MSB-first) engine.
// Each granted frame is reduced to a CRC/source/length result presented on a valid/ready handshake.
module crc8_frame_arb #(
    parameter logic [7:0] INIT   = 8'h00,
    parameter logic [7:0] XOROUT = 8'h00,
    parameter int         LEN_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s0_valid,
    input  logic [7:0]       s0_data,
    input  logic             s0_last,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [7:0]       s1_data,
    input  logic             s1_last,
    output logic             s1_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_crc,
    output logic             m_src,
    output logic [LEN_W-1:0] m_len,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t           state;
    logic             grant;
    logic             prio;
    logic [7:0]       crc;
    logic [LEN_W-1:0] len;

    logic             in_valid;
    logic             in_last;
    logic [7:0]       in_data;
    logic [7:0]       crc_next;
    logic [LEN_W-1:0] len_next;
    logic             winner;

    // One byte of the 0x07 polynomial, folded into eight parallel XOR equations.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        logic [7:0] n;
        x    = c ^ d;
        n[0] = x[7] ^ x[6] ^ x[0];
        n[1] = x[6] ^ x[1] ^ x[0];
        n[2] = x[6] ^ x[2] ^ x[1] ^ x[0];
        n[3] = x[7] ^ x[3] ^ x[2] ^ x[1];
        n[4] = x[4] ^ x[3] ^ x[2];
        n[5] = x[5] ^ x[4] ^ x[3];
        n[6] = x[6] ^ x[5] ^ x[4];
        n[7] = x[7] ^ x[6] ^ x[5];
        return n;
    endfunction

    function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] l);
        return (&l) ? l : l + LEN_W'(1);
    endfunction

    always_comb begin
        in_valid = grant ? s1_valid : s0_valid;
        in_data  = grant ? s1_data  : s0_data;
        in_last  = grant ? s1_last  : s0_last;
        crc_next = crc8_step(crc, in_data);
        len_next = len_sat_inc(len);
        // prio names the requester that wins when both ask at once.
        winner   = s0_valid ? (s1_valid ? prio : 1'b0) : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            grant   <= 1'b0;
            prio    <= 1'b0;
            crc     <= INIT;
            len     <= '0;
            m_valid <= 1'b0;
            m_crc   <= 8'h00;
            m_src   <= 1'b0;
            m_len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_valid || s1_valid) begin
                        grant <= winner;
                        prio  <= ~winner;
                        crc   <= INIT;
                        len   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        crc <= crc_next;
                        len <= len_next;
                        if (in_last) begin
                            state   <= RESULT;
                            m_valid <= 1'b1;
                            m_crc   <= crc_next ^ XOROUT;
                            m_src   <= grant;
                            m_len   <= len_next;
                        end
                    end
                end
                RESULT: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Readies decode from registered state only, so no input reaches an output combinationally.
    assign s0_ready = (state == RUN) && !grant;
    assign s1_ready = (state == RUN) &&  grant;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_crc8_frame_arb.sv
// Randomized bench for crc8_frame_arb: per-source frame drivers and a bit-serial CRC reference model.
module tb_crc8_frame_arb;

    localparam int         LEN_W  = 4;
    localparam int         LMAX   = (1 << LEN_W) - 1;
    localparam logic [7:0] INIT   = 8'h00;
    localparam logic [7:0] XOROUT = 8'h00;

    typedef struct packed {
        logic [7:0]       crc;
        logic             src;
        logic [LEN_W-1:0] len;
    } res_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       sv = 2'b00;
    logic [1:0]       sl = 2'b00;
    logic [7:0]       sd [2];
    logic             s0_ready, s1_ready;
    logic             m_valid, m_src, busy;
    logic             m_ready = 1'b0;
    logic [7:0]       m_crc;
    logic [LEN_W-1:0] m_len;

    always #5 clk = ~clk;

    crc8_frame_arb #(.INIT(INIT), .XOROUT(XOROUT), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .s0_valid(sv[0]), .s0_data(sd[0]), .s0_last(sl[0]), .s0_ready(s0_ready),
        .s1_valid(sv[1]), .s1_data(sd[1]), .s1_last(sl[1]), .s1_ready(s1_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_crc(m_crc), .m_src(m_src),
        .m_len(m_len), .busy(busy)
    );

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t obs_q[$];
    int   grant_seq[$];
    int   ready_viol, hold_viol, lat_viol;
    logic [7:0] fb [2][64];
    int   flen[2], fpos[2], frames_left[2];
    bit   fact[2];
    int   gap_pct = 0;
    int   max_len = 8;
    int   mready_mode = 1;

    // Reference CRC: textbook shift-register form, one bit at a time.
    function automatic logic [7:0] ref_crc(input int s, input int n);
        logic [7:0] c;
        c = INIT;
        for (int i = 0; i < n; i++) begin
            c = c ^ fb[s][i];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c ^ XOROUT;
    endfunction

    task automatic arm(input int s, input int n);
        flen[s] = n; fpos[s] = 0; fact[s] = 1'b1;
    endtask

    task automatic new_frame(input int s, input int n);
        for (int i = 0; i < n; i++) fb[s][i] = 8'($urandom);
        arm(s, n);
    endtask

    task automatic clear_sb();
        exp_q.delete(); obs_q.delete(); grant_seq.delete();
        ready_viol = 0; hold_viol = 0; lat_viol = 0;
    endtask

    // One clock: observe at negedge, drive at posedge+1, then check latency/hold at the next negedge.
    task automatic step();
        logic [1:0] rdy;
        bit         pend_lat, hold_pend;
        res_t       r, hold_v;
        rdy = {s1_ready, s0_ready};
        pend_lat = 0; hold_pend = 0;
        if (rdy == 2'b11 || (m_valid && rdy != 2'b00) || (m_valid && !busy) || (rdy != 2'b00 && !busy))
            ready_viol++;
        if (m_valid && m_ready) begin
            r = '{crc: m_crc, src: m_src, len: m_len};
            obs_q.push_back(r);
        end
        if (m_valid && !m_ready) begin
            hold_pend = 1;
            hold_v = '{crc: m_crc, src: m_src, len: m_len};
        end
        for (int s = 0; s < 2; s++) begin
            if (sv[s] && rdy[s]) begin
                if (fpos[s] == 0) grant_seq.push_back(s);
                fpos[s]++;
                if (sl[s]) begin
                    r.crc = ref_crc(s, fpos[s]);
                    r.src = 1'(s);
                    r.len = (fpos[s] > LMAX) ? LEN_W'(LMAX) : LEN_W'(fpos[s]);
                    exp_q.push_back(r);
                    fact[s] = 1'b0;
                    pend_lat = 1;
                end
            end
        end
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            if (!fact[s] && frames_left[s] > 0) begin
                new_frame(s, $urandom_range(max_len, 1));
                frames_left[s]--;
            end
            if (fact[s] && $urandom_range(99, 0) >= gap_pct) begin
                sv[s] = 1'b1; sd[s] = fb[s][fpos[s]]; sl[s] = (fpos[s] == flen[s] - 1);
            end else begin
                sv[s] = 1'b0; sd[s] = 8'($urandom); sl[s] = 1'($urandom);
            end
        end
        case (mready_mode)
            0:       m_ready = ($urandom_range(99, 0) < 70);
            1:       m_ready = 1'b1;
            default: m_ready = 1'b0;
        endcase
        @(negedge clk);
        if (pend_lat && !m_valid) lat_viol++;
        if (hold_pend) begin
            r = '{crc: m_crc, src: m_src, len: m_len};
            if (!m_valid || r != hold_v) hold_viol++;
        end
    endtask

    task automatic run(input int bound, output bit timeout);
        int c;
        c = 0;
        while ((fact[0] || fact[1] || frames_left[0] > 0 || frames_left[1] > 0 ||
                obs_q.size() < exp_q.size() || m_valid) && c < bound) begin
            step();
            c++;
        end
        timeout = (c >= bound);
    endtask

    task automatic do_reset();
        sv = 2'b00; fact[0] = 0; fact[1] = 0; frames_left[0] = 0; frames_left[1] = 0;
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({s1_ready, s0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {s1_ready, s0_ready}); end
        checks++; if (m_crc !== 8'h00) begin errors++; $display("FAIL reset_m_crc got %h want 00", m_crc); end
        checks++; if (m_src !== 1'b0) begin errors++; $display("FAIL reset_m_src got %b want 0", m_src); end
        checks++; if (m_len !== '0) begin errors++; $display("FAIL reset_m_len got %h want 0", m_len); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        bit to;
        clear_sb(); gap_pct = 0; mready_mode = 1;
        fb[0][0] = 8'h01; arm(0, 1); run(50, to);
        checks++; if (to || obs_q.size() != 1) begin errors++; $display("FAIL single01_count got %0d want 1 (timeout=%0d)", obs_q.size(), to); end
        else begin
            checks++; if (obs_q[0].crc !== 8'h07) begin errors++; $display("FAIL single01_crc got %h want 07", obs_q[0].crc); end
            checks++; if (obs_q[0].src !== 1'b0) begin errors++; $display("FAIL single01_src got %b want 0", obs_q[0].src); end
            checks++; if (obs_q[0].len !== LEN_W'(1)) begin errors++; $display("FAIL single01_len got %0d want 1", obs_q[0].len); end
        end
        clear_sb();
        fb[0][0] = 8'h80; arm(0, 1); run(50, to);
        checks++; if (to || obs_q.size() != 1) begin errors++; $display("FAIL single80_count got %0d want 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].crc !== 8'h89) begin errors++; $display("FAIL single80_crc got %h want 89", obs_q[0].crc); end
        end
        checks++; if (lat_viol !== 0) begin errors++; $display("FAIL single_latency got %0d late results want 0", lat_viol); end
    endtask

    task automatic test_check_string();
        bit to;
        clear_sb(); gap_pct = 0; mready_mode = 1;
        for (int i = 0; i < 9; i++) fb[1][i] = 8'h31 + 8'(i);
        arm(1, 9); run(80, to);
        checks++; if (to || obs_q.size() != 1) begin errors++; $display("FAIL string_count got %0d want 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].crc !== 8'hF4) begin errors++; $display("FAIL string_crc got %h want f4", obs_q[0].crc); end
            checks++; if (obs_q[0].src !== 1'b1) begin errors++; $display("FAIL string_src got %b want 1", obs_q[0].src); end
            checks++; if (obs_q[0].len !== LEN_W'(9)) begin errors++; $display("FAIL string_len got %0d want 9", obs_q[0].len); end
        end
        checks++; if (lat_viol !== 0) begin errors++; $display("FAIL string_latency got %0d late results want 0", lat_viol); end
    endtask

    task automatic test_contention();
        bit to;
        do_reset(); clear_sb();
        gap_pct = 0; mready_mode = 1; max_len = 6;
        frames_left[0] = 3; frames_left[1] = 3;
        run(400, to);
        checks++; if (to || grant_seq.size() != 6) begin errors++; $display("FAIL contention_grants got %0d want 6 (timeout=%0d)", grant_seq.size(), to); end
        for (int i = 0; i < grant_seq.size(); i++) begin
            checks++; if (grant_seq[i] != i % 2) begin errors++; $display("FAIL contention_order[%0d] got %0d want %0d", i, grant_seq[i], i % 2); end
        end
        checks++; if (ready_viol !== 0) begin errors++; $display("FAIL contention_ready got %0d bad cycles want 0", ready_viol); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL contention_results got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL contention_res[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit   to;
        int   c;
        res_t cap;
        logic [7:0] want;
        clear_sb(); gap_pct = 0; mready_mode = 2;
        new_frame(0, 4);
        want = ref_crc(0, 4);
        c = 0;
        while (!m_valid && c < 50) begin step(); c++; end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_result_timeout got m_valid %b want 1", m_valid); end
        cap = '{crc: m_crc, src: m_src, len: m_len};
        new_frame(1, 3);
        repeat (5) begin
            step();
            checks++; if (m_valid !== 1'b1 || m_crc !== cap.crc || m_src !== cap.src || m_len !== cap.len)
                begin errors++; $display("FAIL bp_hold got %b/%h/%b/%0d want 1/%h/%b/%0d", m_valid, m_crc, m_src, m_len, cap.crc, cap.src, cap.len); end
            checks++; if ({s1_ready, s0_ready} !== 2'b00 || busy !== 1'b1)
                begin errors++; $display("FAIL bp_ready_busy got ready %b busy %b want 00 1", {s1_ready, s0_ready}, busy); end
        end
        checks++; if (cap.crc !== want || cap.len !== LEN_W'(4)) begin errors++; $display("FAIL bp_value got %h/%0d want %h/4", cap.crc, cap.len, want); end
        mready_mode = 1; run(80, to);
        checks++; if (to || obs_q.size() != 2 || obs_q[0] !== cap || obs_q[1] !== exp_q[1])
            begin errors++; $display("FAIL bp_drain got %0d results want 2 matching", obs_q.size()); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold_count got %0d want 0", hold_viol); end
    endtask

    task automatic test_gaps();
        bit to;
        logic [7:0] a;
        clear_sb(); mready_mode = 1;
        for (int i = 0; i < 12; i++) fb[0][i] = 8'($urandom);
        gap_pct = 0; arm(0, 12); run(100, to);
        a = (obs_q.size() > 0) ? obs_q[0].crc : 8'hxx;
        checks++; if (to || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL gapfree_crc got %h want %h", a, ref_crc(0, 12)); end
        clear_sb();
        gap_pct = 60; arm(0, 12); run(300, to);
        checks++; if (to || obs_q.size() != 1 || obs_q[0].crc !== a) begin errors++; $display("FAIL gaps_crc got %0d results want crc %h", obs_q.size(), a); end
        checks++; if (to || obs_q.size() != 1 || obs_q[0].len !== LEN_W'(12)) begin errors++; $display("FAIL gaps_len got %0d results want len 12", obs_q.size()); end
        gap_pct = 0;
    endtask

    task automatic test_saturation();
        bit to;
        clear_sb(); gap_pct = 0; mready_mode = 1;
        new_frame(1, 20); run(100, to);
        checks++; if (to || obs_q.size() != 1) begin errors++; $display("FAIL sat_count got %0d want 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].len !== 4'hF) begin errors++; $display("FAIL sat_len got %h want f", obs_q[0].len); end
            checks++; if (obs_q[0].crc !== ref_crc(1, 20)) begin errors++; $display("FAIL sat_crc got %h want %h", obs_q[0].crc, ref_crc(1, 20)); end
        end
    endtask

    task automatic test_random();
        bit to;
        do_reset(); clear_sb();
        gap_pct = 30; mready_mode = 0; max_len = 20;
        frames_left[0] = 6; frames_left[1] = 6;
        run(5000, to);
        checks++; if (to || obs_q.size() != 12 || exp_q.size() != 12)
            begin errors++; $display("FAIL rand_count got %0d/%0d want 12/12 (timeout=%0d)", obs_q.size(), exp_q.size(), to); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_res[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (ready_viol + hold_viol + lat_viol != 0)
            begin errors++; $display("FAIL rand_protocol got ready %0d hold %0d lat %0d want 0", ready_viol, hold_viol, lat_viol); end
        gap_pct = 0; mready_mode = 1;
    endtask

    task automatic test_reset_midframe();
        bit to;
        int c;
        clear_sb(); gap_pct = 0; mready_mode = 1;
        new_frame(0, 2); run(50, to);
        clear_sb();
        new_frame(0, 5); new_frame(1, 8);
        c = 0;
        while (fpos[1] < 3 && c < 40) begin step(); c++; end
        checks++; if (grant_seq.size() < 1 || grant_seq[0] != 1) begin errors++; $display("FAIL rr_after_s0 got %0d entries want first grant 1", grant_seq.size()); end
        checks++; if (fpos[1] != 3) begin errors++; $display("FAIL midframe_setup got %0d bytes want 3", fpos[1]); end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || {s1_ready, s0_ready} !== 2'b00)
            begin errors++; $display("FAIL midreset_ctrl got v%b b%b r%b want v0 b0 r00", m_valid, busy, {s1_ready, s0_ready}); end
        checks++; if (m_crc !== 8'h00 || m_src !== 1'b0 || m_len !== '0)
            begin errors++; $display("FAIL midreset_data got %h/%b/%0d want 00/0/0", m_crc, m_src, m_len); end
        fpos[1] = 0;
        clear_sb();
        run(100, to);
        checks++; if (to || grant_seq.size() < 1 || grant_seq[0] != 0) begin errors++; $display("FAIL midreset_grant got %0d entries want first grant 0", grant_seq.size()); end
        checks++; if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[0].src !== 1'b0)
            begin errors++; $display("FAIL midreset_result got %0d results want 2 with s0 first from INIT", obs_q.size()); end
        checks++; if (obs_q.size() == 2 && obs_q[1] !== exp_q[1]) begin errors++; $display("FAIL midreset_s1 got %h want %h", obs_q[1], exp_q[1]); end
    endtask

    initial begin
        sd[0] = 8'h00; sd[1] = 8'h00;
        fact[0] = 0; fact[1] = 0; frames_left[0] = 0; frames_left[1] = 0;
        fpos[0] = 0; fpos[1] = 0; flen[0] = 0; flen[1] = 0;
        clear_sb();
        test_reset();
        test_single_byte();
        test_check_string();
        test_contention();
        test_backpressure();
        test_gaps();
        test_saturation();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_frame_arb.md
Name: crc8_frame_arb

Overview:
Frame-level sequencer that shares one CRC-8 engine (poly x^8+x^2+x+1, 0x07, MSB-first) between two byte-stream requesters. It grants one requester at a time using round-robin, then accumulates the CRC over that requester's whole frame. At end of frame it presents the CRC, source id and byte count on a result handshake. It sits between the packet sources and the framing/check logic that appends or compares the CRC.

Parameters:
INIT, 8'h00, CRC register value loaded at start of every frame
XOROUT, 8'h00, value XORed into the final CRC before output
LEN_W, 16, width of byte-count output

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous reset, active-low (asserted when 0)
s0_valid  in  1  requester 0 byte valid
s0_data  in  8  requester 0 byte (bit 7 first serial bit)
s0_last  in  1  requester 0 final byte of frame
s0_ready  out  1  requester 0 byte accepted when valid&ready
s1_valid  in  1  requester 1 byte valid
s1_data  in  8  requester 1 byte
s1_last  in  1  requester 1 final byte of frame
s1_ready  out  1  requester 1 byte accepted
m_valid  out  1  result valid
m_ready  in  1  result consumer ready
m_crc  out  8  final CRC (crc ^ XOROUT)
m_src  out  1  requester id that produced m_crc
m_len  out  LEN_W  bytes in frame, saturating
busy  out  1  state != IDLE

Behaviour:
- CRC step: x = crc ^ byte; next = F(x), where
  n0=x7^x6^x0, n1=x6^x1^x0, n2=x6^x2^x1^x0, n3=x7^x3^x2^x1,
  n4=x4^x3^x2, n5=x5^x4^x3, n6=x6^x5^x4, n7=x7^x6^x5.
- States: IDLE, RUN, RESULT.
- IDLE: ready low. If any sX_valid, pick the winner, latch grant, set crc=INIT and len=0, and go to RUN next cycle.
- Arbitration: round-robin with frame granularity. The priority pointer favours the requester not granted last. After reset, requester 0 has priority. The pointer updates only when a grant is issued.
- RUN: s<grant>_ready=1; the other ready=0.
  - Each accepted byte updates crc=F(crc^data).
  - Each accepted byte updates len=len+1, saturating at all-ones (no wrap).
  - An accepted byte with last=1 moves to RESULT next cycle with m_valid=1, m_crc=F(crc^data)^XOROUT, m_src=grant, m_len=len+1 (saturated).
  - valid low in RUN: hold state, no update.
  - Requests on the non-granted port are ignored until return to IDLE.
- RESULT: ready low on both ports. m_* held stable while m_valid&!m_ready. On m_valid&m_ready: m_valid=0 the next cycle and go to IDLE.
- Latency and throughput:
  - Grant to first-byte acceptance: 1 cycle (IDLE->RUN).
  - Last byte to m_valid: 1 cycle.
  - Minimum turnaround between frames: 1 IDLE bubble after result handshake.
  - Throughput in RUN: 1 byte/cycle.
- One-byte frame (valid&last on first RUN cycle) is legal; result has len=1.
- Reset (reset==0) in any state, including mid-frame or with m_valid pending:
  - next cycle state=IDLE, m_valid=0, s0_ready=s1_ready=0, busy=0.
  - m_crc=0, m_src=0, m_len=0, crc=INIT, len=0, priority pointer -> requester 0.
  - The partial frame is discarded and no result is emitted.
- Outputs are registered except sX_ready and busy, which decode directly from state/grant with no input-to-output combinational paths.

Test Plan:
- Single byte: s0 sends 8'h01 with last=1 (INIT=0, XOROUT=0) -> m_crc=8'h07, m_src=0, m_len=1; s0 sends 8'h80 alone -> m_crc=8'h89.
- Check string: s1 sends ASCII "123456789" (0x31..0x39), last on 0x39 -> m_crc=8'hF4, m_src=1, m_len=9; result appears 1 cycle after last accepted.
- Contention: s0 and s1 both valid from reset -> s0 frame granted first, then s1, then s0; alternation continues while both keep requesting; non-granted ready stays 0 throughout.
- Backpressure and bubbles:
  - m_ready held low 5 cycles -> m_crc/m_src/m_len stable, both readies 0, busy=1.
  - Gaps (valid low) inside a frame -> CRC unchanged versus gap-free run.
- Saturation: LEN_W=4, 20-byte frame -> m_len=4'hF, CRC still correct.
- Reset mid-frame after 3 bytes of s1, with s0 also waiting -> next cycle m_valid=0, busy=0; the next frame is granted to s0 and its CRC starts from INIT.
